axis_cipher_frame_rx: RTL



---
 rtl/axis_cipher_frame_rx_pkg.sv | 70 +++++++
 rtl/axis_cipher_frame_rx_if.sv | 28 ++
 rtl/axis_cipher_frame_rx.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/axis_cipher_frame_rx_pkg.sv
// Shared definitions for the cipher AXI-Stream frame receiver: beat width,
// frame lengths, encrypt-frame field offsets, FSM state type and the
// beat-index to field/slot decode used by the frame store.
package cipher_axis_pkg;

    localparam int WORD_W       = 32;
    localparam int ENC_WORDS    = 28;
    localparam int DEC_WORDS    = 16;

    localparam int KEY_OFS      = 0;
    localparam int NONCE_OFS    = 8;
    localparam int CTR_OFS      = 10;
    localparam int ENC_DATA_OFS = 12;

    // Wide enough to index every beat of the longest frame.
    localparam int IDX_W        = 5;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DRAIN,
        HOLD
    } rx_state_e;

    typedef enum logic [1:0] {
        FLD_KEY,
        FLD_NONCE,
        FLD_CTR,
        FLD_DATA
    } field_e;

    // slot counts words from the LSB end of the destination field, so the
    // first word of a field lands in its most significant position.
    typedef struct packed {
        field_e     fld;
        logic [3:0] slot;
    } beat_dst_t;

    function automatic logic [IDX_W-1:0] frame_last_idx(input logic dec);
        return dec ? IDX_W'(DEC_WORDS - 1) : IDX_W'(ENC_WORDS - 1);
    endfunction

    function automatic beat_dst_t beat_dst(input logic dec, input logic [IDX_W-1:0] idx);
        beat_dst_t  d;
        logic [3:0] rel;
        d.fld = FLD_DATA;
        rel   = idx[3:0];
        if (!dec) begin
            if (idx < IDX_W'(NONCE_OFS)) begin
                d.fld = FLD_KEY;
                rel   = 4'(idx - IDX_W'(KEY_OFS));
            end else if (idx < IDX_W'(CTR_OFS)) begin
                d.fld = FLD_NONCE;
                rel   = 4'(idx - IDX_W'(NONCE_OFS));
            end else if (idx < IDX_W'(ENC_DATA_OFS)) begin
                d.fld = FLD_CTR;
                rel   = 4'(idx - IDX_W'(CTR_OFS));
            end else begin
                rel   = 4'(idx - IDX_W'(ENC_DATA_OFS));
            end
        end
        case (d.fld)
            FLD_KEY:            d.slot = 4'd7 - rel;
            FLD_NONCE, FLD_CTR: d.slot = 4'd1 - rel;
            default:            d.slot = 4'd15 - rel;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/axis_cipher_frame_rx_if.sv
// Beat-level stream bundle between the cipher core output and the frame
// receiver, including the frame-format select that travels with the beats.
interface axis_cipher_frame_rx_if;
    import cipher_axis_pkg::*;

    logic              encryp_decryp;
    logic [WORD_W-1:0] s_axis_data;
    logic              s_axis_valid;
    logic              s_axis_last;
    logic              s_axis_ready;

    modport master (
        output encryp_decryp,
        output s_axis_data,
        output s_axis_valid,
        output s_axis_last,
        input  s_axis_ready
    );

    modport slave (
        input  encryp_decryp,
        input  s_axis_data,
        input  s_axis_valid,
        input  s_axis_last,
        output s_axis_ready
    );

endinterface

// File: rtl/axis_cipher_frame_rx.sv
// AXI-Stream frame receiver: reassembles 32-bit beats into an encrypt frame
// (key/nonce/counter/data, 28 words) or a decrypt frame (data, 16 words),
// presents it with a valid/ready handshake and flags framing errors.
// Optional build macro FRAME_TIMEOUT_EN adds a mid-frame idle timeout.
//
// state | meaning
// IDLE  | waiting for the first beat of a frame
// RECV  | collecting beats 1..N-1
// DRAIN | frame overran its length; discard until last
// HOLD  | complete frame on the outputs, waiting for frame_ready
module axis_cipher_frame_rx
    import cipher_axis_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   axis_clk,
    input  logic                   axis_reset,
    axis_cipher_frame_rx_if.slave  s_axis,
    output logic [8*WORD_W-1:0]    key,
    output logic [2*WORD_W-1:0]    nonce,
    output logic [2*WORD_W-1:0]    counter,
    output logic [16*WORD_W-1:0]   data,
    output logic                   frame_mode,
    output logic                   frame_valid,
    input  logic                   frame_ready,
    output logic                   len_err,
    output logic [7:0]             err_count
);

    rx_state_e              r_state;
    logic [IDX_W-1:0]       r_cnt;
    logic [IDX_W-1:0]       r_last_idx;
    logic                   r_mode;
    logic                   r_ready;

    // Working copy of the frame being received; the output registers only
    // change when a frame completes, so errors leave the last frame intact.
    logic [8*WORD_W-1:0]    r_wkey;
    logic [2*WORD_W-1:0]    r_wnonce;
    logic [2*WORD_W-1:0]    r_wctr;
    logic [16*WORD_W-1:0]   r_wdata;

    logic [8*WORD_W-1:0]    r_key;
    logic [2*WORD_W-1:0]    r_nonce;
    logic [2*WORD_W-1:0]    r_counter;
    logic [16*WORD_W-1:0]   r_data;
    logic                   r_frame_mode;
    logic                   r_frame_valid;
    logic                   r_len_err;
    logic [7:0]             r_err_count;

    logic                   w_accept;
    logic                   w_dst_dec;
    logic [IDX_W-1:0]       w_idx;
    beat_dst_t              w_dst;
    logic                   w_timeout;
    logic                   w_frame_err;

    assign w_accept  = s_axis.s_axis_valid && r_ready;
    assign w_dst_dec = (r_state == IDLE) ? s_axis.encryp_decryp : r_mode;
    assign w_idx     = (r_state == IDLE) ? '0 : r_cnt;
    assign w_dst     = beat_dst(w_dst_dec, w_idx);

`ifdef FRAME_TIMEOUT_EN
    logic [15:0] r_idle;

    assign w_timeout = ((r_state == RECV) || (r_state == DRAIN)) && !w_accept &&
                       (r_idle == 16'(TIMEOUT_CYCLES - 1));

    // Idle-cycle counter, cleared by every accepted beat and outside a frame.
    always_ff @(posedge axis_clk or posedge axis_reset) begin
        if (axis_reset) begin
            r_idle <= '0;
        end else if (w_accept || !((r_state == RECV) || (r_state == DRAIN))) begin
            r_idle <= '0;
        end else begin
            r_idle <= r_idle + 16'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Framing error detection: early last (including a one-beat frame),
    // missing last at the final index, or a mid-frame timeout.
    always_comb begin
        w_frame_err = 1'b0;
        case (r_state)
            IDLE:    w_frame_err = w_accept && s_axis.s_axis_last;
            RECV:    w_frame_err = w_timeout ||
                                   (w_accept && ((r_cnt == r_last_idx) != s_axis.s_axis_last));
            DRAIN:   w_frame_err = w_timeout;
            default: w_frame_err = 1'b0;
        endcase
    end

    // Frame store: write each accepted beat into its field slot.
    always_ff @(posedge axis_clk or posedge axis_reset) begin
        if (axis_reset) begin
            r_wkey   <= '0;
            r_wnonce <= '0;
            r_wctr   <= '0;
            r_wdata  <= '0;
        end else if (w_accept && ((r_state == IDLE) || (r_state == RECV))) begin
            if ((r_state == IDLE) && s_axis.encryp_decryp) begin
                r_wkey   <= '0;
                r_wnonce <= '0;
                r_wctr   <= '0;
            end
            case (w_dst.fld)
                FLD_KEY:   r_wkey[{w_dst.slot[2:0], 5'd0} +: WORD_W]  <= s_axis.s_axis_data;
                FLD_NONCE: r_wnonce[{w_dst.slot[0], 5'd0} +: WORD_W]  <= s_axis.s_axis_data;
                FLD_CTR:   r_wctr[{w_dst.slot[0], 5'd0} +: WORD_W]    <= s_axis.s_axis_data;
                default:   r_wdata[{w_dst.slot, 5'd0} +: WORD_W]      <= s_axis.s_axis_data;
            endcase
        end
    end

    // Control FSM with registered handshake, frame outputs and error report.
    always_ff @(posedge axis_clk or posedge axis_reset) begin
        if (axis_reset) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_last_idx    <= '0;
            r_mode        <= 1'b0;
            r_ready       <= 1'b0;
            r_key         <= '0;
            r_nonce       <= '0;
            r_counter     <= '0;
            r_data        <= '0;
            r_frame_mode  <= 1'b0;
            r_frame_valid <= 1'b0;
            r_len_err     <= 1'b0;
            r_err_count   <= '0;
        end else begin
            r_len_err <= w_frame_err;
            if (w_frame_err && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end

            case (r_state)
                IDLE: begin
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        r_mode     <= s_axis.encryp_decryp;
                        r_last_idx <= frame_last_idx(s_axis.encryp_decryp);
                        r_cnt      <= IDX_W'(1);
                        if (!s_axis.s_axis_last) begin
                            r_state <= RECV;
                        end
                    end
                end

                RECV: begin
                    if (w_timeout) begin
                        r_state <= IDLE;
                    end else if (w_accept) begin
                        if (r_cnt == r_last_idx) begin
                            if (s_axis.s_axis_last) begin
                                // The final word always lands in data[31:0] and is
                                // still in flight, so it is merged straight in here.
                                r_key         <= r_wkey;
                                r_nonce       <= r_wnonce;
                                r_counter     <= r_wctr;
                                r_data        <= {r_wdata[16*WORD_W-1:WORD_W], s_axis.s_axis_data};
                                r_frame_mode  <= r_mode;
                                r_frame_valid <= 1'b1;
                                r_ready       <= 1'b0;
                                r_state       <= HOLD;
                            end else begin
                                r_state <= DRAIN;
                            end
                        end else if (s_axis.s_axis_last) begin
                            r_state <= IDLE;
                        end else begin
                            r_cnt <= r_cnt + IDX_W'(1);
                        end
                    end
                end

                DRAIN: begin
                    if (w_timeout || (w_accept && s_axis.s_axis_last)) begin
                        r_state <= IDLE;
                    end
                end

                HOLD: begin
                    if (frame_ready) begin
                        r_frame_valid <= 1'b0;
                        r_ready       <= 1'b1;
                        r_state       <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign s_axis.s_axis_ready = r_ready;
    assign key                 = r_key;
    assign nonce               = r_nonce;
    assign counter             = r_counter;
    assign data                = r_data;
    assign frame_mode          = r_frame_mode;
    assign frame_valid         = r_frame_valid;
    assign len_err             = r_len_err;
    assign err_count           = r_err_count;

endmodule
